// File: rtl/fnd_digit_driver.sv
// Four-digit common-anode 7-segment driver: iterative binary-to-BCD conversion,
// tear-free digit commit, and a registered scan path with leading-zero blanking and DP.
//
// state  | meaning
// S_IDLE   | waiting for a value strobe
// S_SHIFT  | one double-dabble adjust+shift per cycle, VALUE_W cycles total
// S_COMMIT | publish the BCD result, then start the next queued value if any
module fnd_digit_driver #(
  parameter int VALUE_W = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [1:0]         i_digit_sel,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_value_valid,
  input  logic               i_blank_lz,
  input  logic [3:0]         i_dp_mask,
  output logic [3:0]         o_fnd_com,
  output logic [7:0]         o_fnd_font,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_clamped
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  localparam int ITER_W = $clog2(VALUE_W + 1);
  localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_VAL);

  state_t               r_state;
  logic [VALUE_W-1:0]   r_bin;
  logic [15:0]          r_bcd;
  logic [ITER_W-1:0]    r_iter;
  logic                 r_clamp_cur;
  logic [VALUE_W-1:0]   r_pend;
  logic                 r_pend_vld;
  logic [15:0]          r_digits;
  logic                 r_done;
  logic                 r_clamped;
  logic [3:0]           r_com;
  logic [7:0]           r_font;

  logic [VALUE_W-1:0]   w_src;
  logic                 w_src_over;
  logic [VALUE_W-1:0]   w_src_sat;
  logic [15:0]          w_bcd_adj;
  logic [3:0]           w_nib;
  logic                 w_blank;
  logic [6:0]           w_seg;
  logic [3:0]           w_com;

  // A fresh strobe always beats the pending entry (newest wins).
  assign w_src      = (r_state == S_COMMIT && !i_value_valid) ? r_pend : i_value;
  assign w_src_over = (w_src > MAX_V);
  assign w_src_sat  = w_src_over ? MAX_V : w_src;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5)
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_iter      <= '0;
      r_clamp_cur <= 1'b0;
      r_pend      <= '0;
      r_pend_vld  <= 1'b0;
      r_digits    <= '0;
      r_done      <= 1'b0;
      r_clamped   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_value_valid) begin
            r_bin       <= w_src_sat;
            r_bcd       <= '0;
            r_clamp_cur <= w_src_over;
            r_iter      <= ITER_W'(VALUE_W - 1);
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          if (i_value_valid) begin
            r_pend     <= i_value;
            r_pend_vld <= 1'b1;
          end
          if (r_iter == '0)
            r_state <= S_COMMIT;
          else
            r_iter <= r_iter - 1'b1;
        end
        S_COMMIT: begin
          r_digits  <= r_bcd;
          r_clamped <= r_clamp_cur;
          r_done    <= 1'b1;
          if (i_value_valid || r_pend_vld) begin
            r_bin       <= w_src_sat;
            r_bcd       <= '0;
            r_clamp_cur <= w_src_over;
            r_iter      <= ITER_W'(VALUE_W - 1);
            r_pend_vld  <= 1'b0;
            r_state     <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_nib   = r_digits[3:0];
    w_blank = 1'b0;
    w_com   = 4'b1110;
    case (i_digit_sel)
      2'd0: begin w_nib = r_digits[3:0];   w_blank = 1'b0;                                w_com = 4'b1110; end
      2'd1: begin w_nib = r_digits[7:4];   w_blank = i_blank_lz && (r_digits[15:4] == '0);  w_com = 4'b1101; end
      2'd2: begin w_nib = r_digits[11:8];  w_blank = i_blank_lz && (r_digits[15:8] == '0);  w_com = 4'b1011; end
      default: begin w_nib = r_digits[15:12]; w_blank = i_blank_lz && (r_digits[15:12] == '0); w_com = 4'b0111; end
    endcase
  end

  always_comb begin
    w_seg = 7'h7F;
    case (w_nib)
      4'd0: w_seg = 7'h40;
      4'd1: w_seg = 7'h79;
      4'd2: w_seg = 7'h24;
      4'd3: w_seg = 7'h30;
      4'd4: w_seg = 7'h19;
      4'd5: w_seg = 7'h12;
      4'd6: w_seg = 7'h02;
      4'd7: w_seg = 7'h78;
      4'd8: w_seg = 7'h00;
      4'd9: w_seg = 7'h10;
      default: w_seg = 7'h7F;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_com  <= 4'b1111;
      r_font <= 8'hFF;
    end else begin
      r_com  <= w_com;
      r_font <= {~i_dp_mask[i_digit_sel], (w_blank ? 7'h7F : w_seg)};
    end
  end

  assign o_fnd_com  = r_com;
  assign o_fnd_font = r_font;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_clamped  = r_clamped;

endmodule

// File: tb/tb_fnd_digit_driver.sv
// Directed bench for fnd_digit_driver: reset state, conversion latency, clamping,
// blanking/DP, pending overwrite and reset abort, with hand-computed expectations.
module tb_fnd_digit_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [13:0] val;
  logic        vld;
  logic        blz;
  logic [3:0]  dpm;
  logic [3:0]  com;
  logic [7:0]  font;
  logic        busy, done, clamped;

  int checks = 0;
  int errors = 0;
  int ndone;
  int first_done;
  int second_done;
  logic [7:0] font_hist [0:45];

  fnd_digit_driver #(.VALUE_W(14), .MAX_VAL(9999)) dut (
    .i_clk(clk), .i_reset(rst), .i_digit_sel(sel), .i_value(val),
    .i_value_valid(vld), .i_blank_lz(blz), .i_dp_mask(dpm),
    .o_fnd_com(com), .o_fnd_font(font), .o_busy(busy), .o_done(done),
    .o_clamped(clamped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scan(input logic [1:0] s, input logic [3:0] exp_com, input logic [7:0] exp_font, input string tag);
    sel = s;
    tick();
    chk({tag, "_com"}, {28'd0, com}, {28'd0, exp_com});
    chk({tag, "_font"}, {24'd0, font}, {24'd0, exp_font});
  endtask

  // Strobe a value and verify busy window N+1..N+15 and done exactly at N+16.
  task automatic convert(input logic [13:0] v, input logic exp_clamp, input string tag);
    val = v;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
      tick();
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_clamp"}, {31'd0, clamped}, {31'd0, exp_clamp});
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0; val = '0; vld = 1'b0; blz = 1'b0; dpm = 4'b0000;
    tick(); tick();
    chk("rst_com", {28'd0, com}, 32'hF);
    chk("rst_font", {24'd0, font}, 32'hFF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_clamped", {31'd0, clamped}, 32'd0);
    rst = 1'b0;

    scan(2'd0, 4'b1110, 8'hC0, "rst_s0");
    scan(2'd1, 4'b1101, 8'hC0, "rst_s1");
    scan(2'd2, 4'b1011, 8'hC0, "rst_s2");
    scan(2'd3, 4'b0111, 8'hC0, "rst_s3");

    convert(14'd1234, 1'b0, "v1234");
    scan(2'd0, 4'b1110, 8'h99, "v1234_s0");
    scan(2'd1, 4'b1101, 8'hB0, "v1234_s1");
    scan(2'd2, 4'b1011, 8'hA4, "v1234_s2");
    scan(2'd3, 4'b0111, 8'hF9, "v1234_s3");

    convert(14'd12000, 1'b1, "v12000");
    scan(2'd0, 4'b1110, 8'h90, "v12000_s0");
    scan(2'd1, 4'b1101, 8'h90, "v12000_s1");
    scan(2'd2, 4'b1011, 8'h90, "v12000_s2");
    scan(2'd3, 4'b0111, 8'h90, "v12000_s3");

    convert(14'd7, 1'b0, "v7");
    blz = 1'b1; dpm = 4'b0010;
    scan(2'd0, 4'b1110, 8'hF8, "v7_lz_s0");
    scan(2'd1, 4'b1101, 8'h7F, "v7_lz_s1");
    scan(2'd2, 4'b1011, 8'hFF, "v7_lz_s2");
    scan(2'd3, 4'b0111, 8'hFF, "v7_lz_s3");
    blz = 1'b0;
    scan(2'd1, 4'b1101, 8'h40, "v7_nz_s1");
    scan(2'd2, 4'b1011, 8'hC0, "v7_nz_s2");
    scan(2'd3, 4'b0111, 8'hC0, "v7_nz_s3");
    dpm = 4'b0000;

    // 100 then 200/300 during SHIFT: 300 overwrites 200 in the pending slot.
    sel = 2'd2;
    ndone = 0; first_done = -1; second_done = -1;
    val = 14'd100; vld = 1'b1;
    tick();
    vld = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      font_hist[k] = font;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
      if (k == 16) chk("pend_busy_hold", {31'd0, busy}, 32'd1);
      if (k == 3)      begin val = 14'd200; vld = 1'b1; end
      else if (k == 6) begin val = 14'd300; vld = 1'b1; end
      else             vld = 1'b0;
      tick();
    end
    chk("pend_ndone", ndone, 32'd2);
    chk("pend_first_at", first_done, 32'd16);
    chk("pend_second_at", second_done, 32'd31);
    chk("pend_show100", {24'd0, font_hist[17]}, 32'hF9);
    chk("pend_show300", {24'd0, font_hist[32]}, 32'hB0);

    // Reset during conversion aborts with no done pulse.
    val = 14'd4321; vld = 1'b1;
    tick();
    vld = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_ndone", ndone, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    scan(2'd0, 4'b1110, 8'hC0, "abort_s0");
    scan(2'd1, 4'b1101, 8'hC0, "abort_s1");
    scan(2'd2, 4'b1011, 8'hC0, "abort_s2");
    scan(2'd3, 4'b0111, 8'hC0, "abort_s3");

    convert(14'd55, 1'b0, "v55");
    scan(2'd0, 4'b1110, 8'h92, "v55_s0");
    scan(2'd1, 4'b1101, 8'h92, "v55_s1");
    scan(2'd2, 4'b1011, 8'hC0, "v55_s2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
